// File: rtl/clk_en_gen.sv
// Clock-enable generator for the clk0 fabric domain.
// Qualifies MMCM lock, releases a downstream reset once lock is stable, and
// produces NCH phase-aligned single-cycle clock enables with runtime-programmable
// divide ratios (shadowed, applied only on period boundaries).
module clk_en_gen #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned LOCK_WAIT = 16,
    parameter int unsigned DEF_DIV   = 2,
    localparam int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ack,
    output logic [NCH-1:0]   ce,
    output logic             ready,
    output logic             rst_out_n
);

    localparam int unsigned LCNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        COUNT,
        RUN
    } state_t;

    state_t            state;
    logic              lock_m;
    logic              lock_s;
    logic [LCNT_W-1:0] lcnt;
    logic              ch_valid;
    logic              running;

    logic [DIV_W-1:0]  cnt    [NCH];
    logic [DIV_W-1:0]  div    [NCH];
    logic [DIV_W-1:0]  shadow [NCH];

    // Channel index range check; trivially true when NCH fills the index space.
    generate
        if (NCH == (1 << CH_W)) begin : g_full_range
            assign ch_valid = 1'b1;
        end else begin : g_part_range
            assign ch_valid = (cfg_ch < CH_W'(NCH));
        end
    endgenerate

    // Channels only count while RUN is held; the edge that drops out of RUN
    // already sees lock_s low and clears them together with ready.
    assign running = (state == RUN) && lock_s;

    // Two-flop synchroniser for the asynchronous MMCM lock status.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= locked;
            lock_s <= lock_m;
        end
    end

    // Lock qualification FSM; ready and rst_out_n are registered with the state.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            lcnt      <= '0;
            ready     <= 1'b0;
            rst_out_n <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= COUNT;
                        lcnt  <= '0;
                    end
                end
                COUNT: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (lcnt == LCNT_W'(LOCK_WAIT - 1)) begin
                        state     <= RUN;
                        ready     <= 1'b1;
                        rst_out_n <= 1'b1;
                    end else begin
                        lcnt <= lcnt + LCNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        ready     <= 1'b0;
                        rst_out_n <= 1'b0;
                    end
                end
                default: begin
                    state     <= WAIT_LOCK;
                    ready     <= 1'b0;
                    rst_out_n <= 1'b0;
                end
            endcase
        end
    end

    // Write acknowledge: one-cycle pulse for every write to an existing channel.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= cfg_we && ch_valid;
        end
    end

    // Per-channel divider: shadow captures writes, div reloads only when the
    // channel is idle or at its wrap edge so no period is truncated or merged.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ce <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i]    <= '0;
                div[i]    <= DIV_W'(DEF_DIV);
                shadow[i] <= DIV_W'(DEF_DIV);
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cfg_we && ch_valid && (cfg_ch == CH_W'(i))) begin
                    shadow[i] <= cfg_div;
                end
                if (!running || (div[i] == '0)) begin
                    cnt[i] <= '0;
                    ce[i]  <= 1'b0;
                    div[i] <= shadow[i];
                end else if (cnt[i] == (div[i] - DIV_W'(1))) begin
                    cnt[i] <= '0;
                    ce[i]  <= 1'b1;
                    div[i] <= shadow[i];
                end else begin
                    cnt[i] <= cnt[i] + DIV_W'(1);
                    ce[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen (NCH=3 so that channel index 3 is out of range).
// Edge k of a scenario is the k-th rising edge after the scenario's first
// stimulus; inputs change 1 ns after an edge and outputs are sampled there too.
module tb_clk_en_gen;

    localparam int NCH       = 3;
    localparam int DIV_W     = 8;
    localparam int LOCK_WAIT = 16;

    logic             clkin = 1'b0;
    logic             rst_n = 1'b1;
    logic             locked = 1'b0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_ack;
    logic [NCH-1:0]   ce;
    logic             ready;
    logic             rst_out_n;

    // Observed vector: {ready, rst_out_n, cfg_ack, ce[2:0]}
    typedef logic [5:0] obs_t;
    obs_t obs;
    assign obs = {ready, rst_out_n, cfg_ack, ce};

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   k_now    = 0;

    clk_en_gen #(
        .NCH(NCH),
        .DIV_W(DIV_W),
        .LOCK_WAIT(LOCK_WAIT),
        .DEF_DIV(2)
    ) dut (
        .clkin(clkin),
        .rst_n(rst_n),
        .locked(locked),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_ack(cfg_ack),
        .ce(ce),
        .ready(ready),
        .rst_out_n(rst_out_n)
    );

    always #5 clkin = ~clkin;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected enable: RUN entered on edge t0, pulses at t0+d, t0+2d, ...
    function automatic logic pulse(int k, int t0, int d);
        return (k > t0) && (((k - t0) % d) == 0);
    endfunction

    function automatic obs_t mk(logic rdy, logic ack, logic [2:0] c);
        return {rdy, rdy, ack, c};
    endfunction

    task automatic tick;
        @(posedge clkin);
        #1;
    endtask

    task automatic do_reset;
        rst_n  = 1'b0;
        cfg_we = 1'b0;
        locked = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        obs_t e;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", obs, 6'b0);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(6'b0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_hold i=%0d got=%b exp=%b", i, obs, e);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(6'b0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_release i=%0d got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    // locked rises before edge 1: ready at edge 19, div=2 pulses at 21, 23, ...
    task automatic test_lock_and_run;
        obs_t e;
        for (int k = 1; k <= 30; k++) begin
            if (k == 1) locked = 1'b1;
            exp_q.push_back(mk(k >= 19, 1'b0, {3{pulse(k, 19, 2)}}));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL lock_run k=%0d got=%b exp=%b", k, obs, e);
            end
            k_now = k;
        end
    endtask

    // Drop lock, then high 10 cycles, low 1, high again: ready 19 edges after final rise.
    task automatic test_glitch;
        obs_t e;
        for (int k = k_now + 1; k <= k_now + 6; k++) begin
            if (k == k_now + 1) locked = 1'b0;
            exp_q.push_back(mk(k < k_now + 3, 1'b0, {3{pulse(k, 19, 2) && (k < k_now + 3)}}));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL lock_drop1 k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        for (int k = 1; k <= 34; k++) begin
            if (k == 1)  locked = 1'b1;
            if (k == 11) locked = 1'b0;
            if (k == 12) locked = 1'b1;
            exp_q.push_back(mk(k >= 30, 1'b0, {3{pulse(k, 30, 2)}}));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL glitch k=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    // ch0 div=5, retuned to 3 mid-period: pulses 24, 29 then 32, 35, 38.
    task automatic test_retune;
        obs_t e;
        logic c0;
        do_reset();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        exp_q.push_back(mk(1'b0, 1'b1, 3'b000));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL retune_idle_ack got=%b exp=%b", obs, e);
        end
        cfg_we = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) locked = 1'b1;
            if (k == 27) begin
                cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
            end
            if (k == 28) cfg_we = 1'b0;
            c0 = (k == 24) || (k == 29) || pulse(k, 29, 3);
            exp_q.push_back(mk(k >= 19, k == 27, {pulse(k, 19, 2), pulse(k, 19, 2), c0}));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL retune k=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    // ch1 disabled then set to 1 in RUN; ch2 back-to-back writes (last wins); ch3 invalid.
    task automatic test_disable_and_invalid;
        obs_t e;
        logic [1:0] pch [4];
        logic [7:0] pdv [4];
        logic       pak [4];
        pch = '{2'd1, 2'd2, 2'd2, 2'd3};
        pdv = '{8'd0, 8'd9, 8'd1, 8'd7};
        pak = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_ch = pch[i]; cfg_div = pdv[i];
            exp_q.push_back(mk(1'b0, pak[i], 3'b000));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL cfg_idle i=%0d got=%b exp=%b", i, obs, e);
            end
        end
        cfg_we = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) locked = 1'b1;
            if (k == 22) begin
                cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
            end
            if (k == 23) cfg_we = 1'b0;
            if (k == 25) begin
                cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1;
            end
            if (k == 26) cfg_we = 1'b0;
            exp_q.push_back(mk(k >= 19, k == 25, {k >= 20, k >= 27, pulse(k, 19, 2)}));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL disable_invalid k=%0d got=%b exp=%b", k, obs, e);
            end
            k_now = k;
        end
    endtask

    // Lock lost in RUN: ready, rst_out_n and all enables low on the third edge.
    task automatic test_lock_loss;
        obs_t e;
        logic run;
        for (int k = k_now + 1; k <= k_now + 8; k++) begin
            if (k == k_now + 1) locked = 1'b0;
            run = (k < k_now + 3);
            exp_q.push_back(mk(run, 1'b0, {run, run, pulse(k, 19, 2) && run}));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL lock_loss k=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    // Async reset mid-period after a pending ch0 write of 7: divs return to 2.
    task automatic test_async_reset;
        obs_t e;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            if (k == 1) locked = 1'b1;
            if (k == 24) begin
                cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7;
            end
            if (k == 25) cfg_we = 1'b0;
            exp_q.push_back(mk(k >= 19, k == 24, {3{pulse(k, 19, 2)}}));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL pre_reset k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=%b", obs, 6'b0);
        end
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            exp_q.push_back(mk(k >= 19, 1'b0, {3{pulse(k, 19, 2)}}));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL post_reset k=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_and_run();
        test_glitch();
        test_retune();
        test_disable_and_invalid();
        test_lock_loss();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
